// File: rtl/proj_calc_sequencer_pkg.sv
// Shared constants and state encoding for the projection/compress sequencer
// and the accumulate/compress datapath that decodes its beat counter.
package proj_calc_sequencer_pkg;

  localparam int LAST_BEAT = 69;
  localparam int CNT_W     = $clog2(LAST_BEAT);
  localparam int FRM_W     = 16;

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(35);
  localparam logic [CNT_W-1:0] ADD1_CNT = CNT_W'(51);
  localparam logic [CNT_W-1:0] ADD2_CNT = CNT_W'(67);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BEAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Returns {is_load_beat, is_add_beat} for a counter value.
  function automatic logic [1:0] beat_decode(input logic [CNT_W-1:0] c);
    beat_decode = {c == LOAD_CNT, (c == ADD1_CNT) || (c == ADD2_CNT)};
  endfunction

endpackage

// File: rtl/proj_calc_sequencer_if.sv
// Control/handshake bundle between the sequencer and its environment.
interface proj_calc_sequencer_if;
  import proj_calc_sequencer_pkg::*;

  // Handshakes: a beat transfers on a cycle where in_vld & in_rdy (dp_vld);
  // the result transfers on a cycle where out_vld & out_rdy. A valid, once
  // raised by its source, is never dropped before the matching ready.
  logic             start;
  logic             abort;
  logic             in_vld;
  logic             in_rdy;
  logic             dp_vld;
  logic [CNT_W-1:0] cnt;
  logic             acc_load;
  logic             acc_add;
  logic             ans_latch;
  logic             out_vld;
  logic             out_rdy;
  logic             busy;
  logic             err;
  logic [FRM_W-1:0] frm_cnt;
  state_e           dbg_state;

  modport master (
    output start, abort, in_vld, out_rdy,
    input  in_rdy, dp_vld, cnt, acc_load, acc_add, ans_latch,
           out_vld, busy, err, frm_cnt, dbg_state
  );

  modport slave (
    input  start, abort, in_vld, out_rdy,
    output in_rdy, dp_vld, cnt, acc_load, acc_add, ans_latch,
           out_vld, busy, err, frm_cnt, dbg_state
  );
endinterface

// File: rtl/proj_calc_sequencer.sv
// Beat counter, pass FSM and beat decodes for one projection/compress pass
// of the three-lane dot-product accumulate datapath.
module proj_calc_sequencer
  import proj_calc_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  proj_calc_sequencer_if.slave  bus
);

  state_e           state;
  logic [CNT_W-1:0] cnt_q;
  logic             out_vld_q;
  logic             err_q;
  logic [FRM_W-1:0] frm_q;
  logic             in_rdy_c;
  logic             dp_vld_c;
  logic [1:0]       dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
      frm_q     <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        // Abort wins over every transition; only an in-flight pass flags err.
        state     <= ST_IDLE;
        cnt_q     <= '0;
        out_vld_q <= 1'b0;
        err_q     <= (state == ST_RUN) || (state == ST_DRAIN);
      end else begin
        case (state)
          ST_IDLE: begin
            cnt_q <= '0;
            if (bus.start) state <= ST_RUN;
          end
          ST_RUN: begin
            if (bus.in_vld) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == ADD2_CNT) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (cnt_q == LAST_CNT) begin
              state     <= ST_DONE;
              cnt_q     <= '0;
              out_vld_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_DONE: begin
            if (bus.out_rdy) begin
              frm_q     <= frm_q + FRM_W'(1);
              out_vld_q <= 1'b0;
              state     <= bus.start ? ST_RUN : ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    in_rdy_c = (state == ST_RUN);
    dp_vld_c = bus.in_vld & in_rdy_c;
    dec      = beat_decode(cnt_q);
  end

  assign bus.in_rdy    = in_rdy_c;
  assign bus.dp_vld    = dp_vld_c;
  assign bus.cnt       = cnt_q;
  assign bus.acc_load  = dp_vld_c & dec[1];
  assign bus.acc_add   = dp_vld_c & dec[0];
  assign bus.ans_latch = (cnt_q == LAST_CNT);
  assign bus.out_vld   = out_vld_q;
  assign bus.busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.err       = err_q;
  assign bus.frm_cnt   = frm_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_proj_calc_sequencer.sv
// Directed bench for proj_calc_sequencer with hand-computed expectations.
module tb_proj_calc_sequencer;
  import proj_calc_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  proj_calc_sequencer_if bus ();

  proj_calc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int beats;
    logic v;
    logic [4:0] got;
    logic [4:0] want;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;

    // reset state
    #12;
    chk("rst_state", bus.dbg_state, ST_IDLE);
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_frm", bus.frm_cnt, 0);
    chk("rst_dec", {bus.in_rdy, bus.dp_vld, bus.acc_load, bus.acc_add, bus.ans_latch}, 0);
    rst_n = 1'b1;
    step();

    // full pass, continuous beats, consumer always ready
    bus.start = 1'b1;
    bus.in_vld = 1'b1;
    bus.out_rdy = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
      got  = {bus.dp_vld, bus.acc_load, bus.acc_add, bus.ans_latch, bus.out_vld};
      want = {(c >= 1 && c <= 68), (c == 36), (c == 52 || c == 68), (c == 70), (c == 71)};
      chk($sformatf("p1_dec_c%0d", c), got, want);
    end
    chk("p1_frm", bus.frm_cnt, 1);
    chk("p1_state", bus.dbg_state, ST_IDLE);

    // toggling in_vld: counter advances only on gated beats
    bus.out_rdy = 1'b0;
    bus.in_vld = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    beats = 0;
    v = 1'b1;
    n = 0;
    while (bus.dbg_state == ST_RUN && n < 300) begin
      bus.in_vld = v;
      #1;
      chk("tg_cnt", bus.cnt, beats);
      chk("tg_load", bus.acc_load, v && beats == 35);
      chk("tg_add", bus.acc_add, v && (beats == 51 || beats == 67));
      if (v) beats++;
      v = ~v;
      n++;
      step();
    end
    chk("tg_beats", beats, 68);
    chk("tg_state", bus.dbg_state, ST_DRAIN);
    chk("tg_cnt68", bus.cnt, 68);
    bus.in_vld = 1'b0;
    step();
    chk("tg_latch", bus.ans_latch, 1);
    chk("tg_cnt69", bus.cnt, 69);
    step();
    chk("tg_done_vld", bus.out_vld, 1);
    chk("tg_done_cnt", bus.cnt, 0);

    // consumer stalls for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("st_vld", bus.out_vld, 1);
      chk("st_cnt", bus.cnt, 0);
      chk("st_latch", bus.ans_latch, 0);
      chk("st_frm", bus.frm_cnt, 1);
    end
    bus.out_rdy = 1'b1;
    step();
    chk("st_frm_inc", bus.frm_cnt, 2);
    chk("st_vld_clr", bus.out_vld, 0);
    chk("st_idle", bus.dbg_state, ST_IDLE);

    // back-to-back passes
    bus.out_rdy = 1'b0;
    bus.in_vld = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 1;
    while (!bus.out_vld && n < 200) begin
      step();
      n++;
    end
    chk("bb_lat1", n, 71);
    bus.start = 1'b1;
    bus.out_rdy = 1'b1;
    step();
    bus.start = 1'b0;
    bus.out_rdy = 1'b0;
    chk("bb_state", bus.dbg_state, ST_RUN);
    chk("bb_cnt", bus.cnt, 0);
    chk("bb_frm", bus.frm_cnt, 3);
    chk("bb_vld_clr", bus.out_vld, 0);
    n = 0;
    while (!bus.out_vld && n < 200) begin
      step();
      n++;
    end
    chk("bb_lat2", n, 70);
    bus.out_rdy = 1'b1;
    step();
    chk("bb_frm2", bus.frm_cnt, 4);
    chk("bb_idle", bus.dbg_state, ST_IDLE);

    // abort at cnt 50, start mid-run ignored
    bus.in_vld = 1'b0;
    bus.start = 1'b1;
    step();
    bus.in_vld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.start = (i == 20);
      step();
    end
    bus.start = 1'b0;
    chk("ab_cnt50", bus.cnt, 50);
    chk("ab_busy", bus.busy, 1);
    bus.abort = 1'b1;
    #1;
    chk("ab_no_add", bus.acc_add, 0);
    step();
    bus.abort = 1'b0;
    chk("ab_state", bus.dbg_state, ST_IDLE);
    chk("ab_cnt", bus.cnt, 0);
    chk("ab_err", bus.err, 1);
    chk("ab_frm", bus.frm_cnt, 4);
    step();
    chk("ab_err_pulse", bus.err, 0);
    chk("ab_latch", bus.ans_latch, 0);

    // abort in DONE
    bus.out_rdy = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 1;
    while (!bus.out_vld && n < 200) begin
      step();
      n++;
    end
    chk("ad_lat", n, 71);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ad_state", bus.dbg_state, ST_IDLE);
    chk("ad_vld", bus.out_vld, 0);
    chk("ad_err", bus.err, 0);
    chk("ad_frm", bus.frm_cnt, 4);

    // asynchronous reset in DRAIN at cnt 68
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (68) step();
    chk("rd_state", bus.dbg_state, ST_DRAIN);
    chk("rd_cnt", bus.cnt, 68);
    rst_n = 1'b0;
    #1;
    chk("rd_cnt0", bus.cnt, 0);
    chk("rd_state0", bus.dbg_state, ST_IDLE);
    chk("rd_vld0", bus.out_vld, 0);
    chk("rd_frm0", bus.frm_cnt, 0);
    step();
    chk("rd_latch", bus.ans_latch, 0);
    rst_n = 1'b1;
    step();
    chk("rd_idle", bus.dbg_state, ST_IDLE);
    chk("rd_cnt_idle", bus.cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
